// File: rtl/jk_bank_ctrl.sv
// Command sequencer driving a bank of synchronous-reset JK flip-flops.
// Single-cycle bit operations and multi-cycle up/down count runs are decoded into per-bit J/K drives.

module jk_sync_res (
    input  logic clk,
    input  logic sync_reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_SET    = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [LEN_W-1:0] step_reg, step_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] j_vec, k_vec;
    logic [WIDTH-1:0] up_carry, dn_borrow;
    logic             is_count;

    assign cmd_ready = (state_reg == IDLE) && !sync_reset;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign is_count  = (op_reg == OP_UP) || (op_reg == OP_DOWN);

    // Ripple toggle-enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    assign up_carry[0]  = 1'b1;
    assign dn_borrow[0] = 1'b1;
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
            assign up_carry[gi]  = up_carry[gi-1] & q[gi-1];
            assign dn_borrow[gi] = dn_borrow[gi-1] & ~q[gi-1];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        data_next  = data_reg;
        step_next  = step_reg;
        done_next  = 1'b0;
        j_vec      = '0;
        k_vec      = '0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_next    = cmd_op;
                    data_next  = cmd_data;
                    step_next  = cmd_len;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                case (op_reg)
                    OP_LOAD:   begin j_vec = data_reg; k_vec = ~data_reg; end
                    OP_CLEAR:  k_vec = data_reg;
                    OP_SET:    j_vec = data_reg;
                    OP_TOGGLE: begin j_vec = data_reg; k_vec = data_reg; end
                    OP_UP:     if (step_reg != '0) begin j_vec = up_carry; k_vec = up_carry; end
                    OP_DOWN:   if (step_reg != '0) begin j_vec = dn_borrow; k_vec = dn_borrow; end
                    default:   ;
                endcase
                if (is_count && (step_reg > LEN_W'(1))) begin
                    step_next = step_reg - LEN_W'(1);
                end else begin
                    step_next  = '0;
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            data_reg  <= '0;
            step_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            data_reg  <= data_next;
            step_reg  <= step_next;
            done_reg  <= done_next;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
            jk_sync_res u_ff (
                .clk        (clk),
                .sync_reset (sync_reset),
                .j          (j_vec[gi]),
                .k          (k_vec[gi]),
                .q          (q[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl: bit ops, count runs with wrap, held-valid throughput,
// reset mid-run and the NOP-like cases.

module tb_jk_bank_ctrl;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jk_bank_ctrl #(.WIDTH(4), .LEN_W(4)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, let it be accepted on the next edge, then withdraw it.
    task automatic issue(input logic [2:0] op, input logic [3:0] data, input logic [3:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic single_op(input string tag, input logic [2:0] op, input logic [3:0] data,
                             input logic [3:0] exp_q);
        issue(op, data, 4'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_q"}, 32'(q), 32'(exp_q));
        check({tag, "_done"}, 32'(done), 32'd1);
        $display("op=%b data=%b -> q=%b done=%b", op, data, q, done);
    endtask

    logic [3:0] up_exp [5];
    logic [3:0] dn_exp [3];
    logic [2:0] b2b_op [4];
    logic [3:0] b2b_dat [4];
    logic [3:0] b2b_q [4];
    int         acc_cyc [4];
    int         idx;
    int         n_done;
    logic       acc;

    initial begin
        sync_reset = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_data   = 4'd0;
        cmd_len    = 4'd0;
        up_exp  = '{4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
        dn_exp  = '{4'b0000, 4'b1111, 4'b1110};
        b2b_op  = '{3'b001, 3'b100, 3'b011, 3'b010};
        b2b_dat = '{4'b0011, 4'b1111, 4'b0001, 4'b0100};
        b2b_q   = '{4'b0011, 4'b1100, 4'b1101, 4'b1001};

        // 1: reset and LOAD
        tick();
        tick();
        check("rst_q", 32'(q), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        sync_reset = 1'b0;
        #1;
        check("rel_ready", 32'(cmd_ready), 32'd1);
        issue(3'b001, 4'b1010, 4'd0);
        check("load_q_before", 32'(q), 32'd0);
        check("load_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        check("load_q", 32'(q), 32'b1010);
        check("load_done", 32'(done), 32'd1);
        check("load_ready", 32'(cmd_ready), 32'd1);
        $display("LOAD 1010 -> q=%b done=%b ready=%b", q, done, cmd_ready);
        tick();
        check("load_done_drop", 32'(done), 32'd0);

        // 2: bit operations
        single_op("toggle", 3'b100, 4'b0110, 4'b1100);
        single_op("set", 3'b011, 4'b0001, 4'b1101);
        single_op("clear", 3'b010, 4'b1000, 4'b0101);

        // 3: COUNT_UP len=5 with wrap
        single_op("load1101", 3'b001, 4'b1101, 4'b1101);
        issue(3'b101, 4'd0, 4'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("up_busy%0d", k), 32'(busy), 32'd1);
            tick();
            check($sformatf("up_q%0d", k), 32'(q), 32'(up_exp[k]));
            check($sformatf("up_done%0d", k), 32'(done), (k == 4) ? 32'd1 : 32'd0);
            $display("COUNT_UP step %0d -> q=%b done=%b", k + 1, q, done);
        end
        check("up_idle", 32'(busy), 32'd0);

        // 4: COUNT_DOWN len=3 with wrap
        single_op("load0001", 3'b001, 4'b0001, 4'b0001);
        issue(3'b110, 4'd0, 4'd3);
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) check($sformatf("dn_q%0d", k), 32'(q), 32'(dn_exp[k]));
            if (done) n_done++;
            $display("COUNT_DOWN cycle %0d -> q=%b done=%b", k + 1, q, done);
        end
        check("dn_done_count", 32'(n_done), 32'd1);
        check("dn_final_q", 32'(q), 32'b1110);

        // 5: cmd_valid held high; junk LOAD 1111 offered whenever busy
        idx       = 0;
        n_done    = 0;
        cmd_valid = 1'b1;
        cmd_op    = b2b_op[0];
        cmd_data  = b2b_dat[0];
        cmd_len   = 4'd0;
        for (int c = 0; c < 10; c++) begin
            acc = cmd_valid & cmd_ready;
            tick();
            if (acc) begin
                acc_cyc[idx] = c;
                idx++;
            end
            if (done) begin
                check($sformatf("b2b_q%0d", n_done), 32'(q), 32'(b2b_q[n_done]));
                n_done++;
            end
            $display("b2b cycle %0d accepted=%b q=%b done=%b", c, acc, q, done);
            if (idx >= 4) begin
                cmd_valid = 1'b0;
            end else if (cmd_ready) begin
                cmd_op   = b2b_op[idx];
                cmd_data = b2b_dat[idx];
            end else begin
                cmd_op   = 3'b001;
                cmd_data = 4'b1111;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", 32'(idx), 32'd4);
        check("b2b_dones", 32'(n_done), 32'd4);
        check("b2b_span", 32'(acc_cyc[3] - acc_cyc[0]), 32'd6);
        check("b2b_final_q", 32'(q), 32'b1001);

        // 6: reset in the middle of COUNT_UP len=10 from 1001
        issue(3'b101, 4'd0, 4'd10);
        tick();
        tick();
        check("abort_q_pre", 32'(q), 32'b1011);
        sync_reset = 1'b1;
        tick();
        check("abort_q", 32'(q), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd0);
        sync_reset = 1'b0;
        tick();
        check("abort_ready_rel", 32'(cmd_ready), 32'd1);
        check("abort_done_rel", 32'(done), 32'd0);
        check("abort_q_rel", 32'(q), 32'd0);
        $display("reset mid-count -> q=%b done=%b ready=%b", q, done, cmd_ready);

        single_op("load0110", 3'b001, 4'b0110, 4'b0110);
        single_op("op111", 3'b111, 4'b1111, 4'b0110);
        issue(3'b101, 4'd0, 4'd0);
        tick();
        check("up0_q", 32'(q), 32'b0110);
        check("up0_done", 32'(done), 32'd1);
        check("up0_ready", 32'(cmd_ready), 32'd1);
        $display("COUNT_UP len=0 -> q=%b done=%b", q, done);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
